// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus: op codes, receive FSM states and
// default field widths.
package serial_bus_pkg;

    localparam int SLAVE_ADDR_SIZE_DEF = 12;
    localparam int WORD_SIZE_DEF       = 8;
    localparam int BURST_SIZE_DEF      = 15;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        S_READ    = 3'd1,
        S_WRITE   = 3'd2,
        S_B_READ  = 3'd3,
        S_B_WRITE = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_RX,
        BURST_RX,
        DATA_RX,
        MEM_WR,
        MEM_RD,
        DONE
    } sip_state_e;

    function automatic logic is_valid_op(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd4);
    endfunction

    function automatic logic is_burst(input op_e op);
        return (op == S_B_READ) || (op == S_B_WRITE);
    endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out register, LSB first, with a bit counter.
// data_o shows the word including the bit being shifted this cycle, so on
// the cycle full_o pulses data_o already holds the complete word.
module sipo_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign full_o = shift_i && (cnt_q == CW'(WIDTH - 1));
    assign data_o = data_d;

    // Next shift value and bit count; counter restarts after a full word.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
        data_d = data_q;
        cnt_d  = cnt_q;
        if (shift_i) begin
            data_d = {bit_i, data_q[WIDTH-1:1]};
        end
        if (clr_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            cnt_d = full_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Shift register and counter state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/slave_in_port.sv
// Slave-side receive stage: deserialises address, burst length and write
// data from the bus and issues word requests to the memory core with an
// auto-incrementing, wrapping address.
module slave_in_port #(
    parameter int SLAVE_ADDR_SIZE = 12,
    parameter int WORD_SIZE       = 8,
    parameter int BURST_SIZE      = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sel,
    input  logic [2:0]                 instruction,
    input  logic                       addr_bus,
    input  logic                       burst_size_bus,
    input  logic                       w_data_bus,
    input  logic                       m_valid,
    output logic                       s_ready,
    output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]       mem_wdata,
    output logic                       mem_we,
    output logic                       mem_re,
    input  logic                       mem_ready,
    output logic                       addr_done,
    output logic                       tx_done,
    output logic                       abort
);

    import serial_bus_pkg::*;

    sip_state_e                 state_q, state_d;
    op_e                        op_q, op_d;
    logic [BURST_SIZE-1:0]      cnt_q, cnt_d;
    logic [SLAVE_ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]       mem_wdata_q, mem_wdata_d;
    logic s_ready_q, s_ready_d;
    logic mem_we_q, mem_we_d;
    logic mem_re_q, mem_re_d;
    logic addr_done_q, addr_done_d;
    logic tx_done_q, tx_done_d;
    logic abort_q, abort_d;

    logic                       accept, sipo_clr;
    logic [SLAVE_ADDR_SIZE-1:0] addr_word;
    logic [BURST_SIZE-1:0]      burst_word;
    logic [WORD_SIZE-1:0]       data_word;
    logic                       addr_full, burst_full, data_full;

    assign accept   = m_valid && s_ready_q && sel;
    assign sipo_clr = (state_q == IDLE);

    sipo_shift #(.WIDTH(SLAVE_ADDR_SIZE)) u_addr_sipo (
        .clk(clk), .rst(rst), .clr_i(sipo_clr),
        .shift_i(accept && (state_q == ADDR_RX)), .bit_i(addr_bus),
        .data_o(addr_word), .full_o(addr_full)
    );

    sipo_shift #(.WIDTH(BURST_SIZE)) u_burst_sipo (
        .clk(clk), .rst(rst), .clr_i(sipo_clr),
        .shift_i(accept && (state_q == BURST_RX)), .bit_i(burst_size_bus),
        .data_o(burst_word), .full_o(burst_full)
    );

    sipo_shift #(.WIDTH(WORD_SIZE)) u_data_sipo (
        .clk(clk), .rst(rst), .clr_i(sipo_clr),
        .shift_i(accept && (state_q == DATA_RX)), .bit_i(w_data_bus),
        .data_o(data_word), .full_o(data_full)
    );

    // Next-state and registered-output logic; a dropped sel aborts any active transfer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        addr_done_d = 1'b0;
        tx_done_d   = 1'b0;
        abort_d     = 1'b0;

        if (state_q != IDLE && state_q != DONE && !sel) begin
            abort_d = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sel && is_valid_op(instruction)) begin
                        op_d    = op_e'(instruction);
                        state_d = ADDR_RX;
                    end
                end
                ADDR_RX: begin
                    if (addr_full) begin
                        mem_addr_d  = addr_word;
                        addr_done_d = 1'b1;
                        cnt_d       = BURST_SIZE'(1);
                        if (is_burst(op_q)) begin
                            state_d = BURST_RX;
                        end else if (op_q == S_WRITE) begin
                            state_d = DATA_RX;
                        end else begin
                            state_d  = MEM_RD;
                            mem_re_d = 1'b1;
                        end
                    end
                end
                BURST_RX: begin
                    if (burst_full) begin
                        // A zero length still transfers one word.
                        cnt_d = (burst_word == '0) ? BURST_SIZE'(1) : burst_word;
                        if (op_q == S_B_WRITE) begin
                            state_d = DATA_RX;
                        end else begin
                            state_d  = MEM_RD;
                            mem_re_d = 1'b1;
                        end
                    end
                end
                DATA_RX: begin
                    if (data_full) begin
                        mem_wdata_d = data_word;
                        mem_we_d    = 1'b1;
                        state_d     = MEM_WR;
                    end
                end
                MEM_WR: begin
                    if (mem_ready) begin
                        cnt_d      = cnt_q - 1'b1;
                        mem_addr_d = mem_addr_q + 1'b1;
                        if (cnt_q == BURST_SIZE'(1)) begin
                            state_d   = DONE;
                            tx_done_d = 1'b1;
                        end else begin
                            state_d = DATA_RX;
                        end
                    end else begin
                        mem_we_d = 1'b1;
                    end
                end
                MEM_RD: begin
                    if (mem_ready) begin
                        cnt_d      = cnt_q - 1'b1;
                        mem_addr_d = mem_addr_q + 1'b1;
                        if (cnt_q == BURST_SIZE'(1)) begin
                            state_d   = DONE;
                            tx_done_d = 1'b1;
                        end else begin
                            mem_re_d = 1'b1;
                        end
                    end else begin
                        mem_re_d = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        s_ready_d = (state_d == IDLE) || (state_d == ADDR_RX) ||
                    (state_d == BURST_RX) || (state_d == DATA_RX);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_NONE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            addr_done_q <= 1'b0;
            tx_done_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            addr_done_q <= addr_done_d;
            tx_done_q   <= tx_done_d;
            abort_q     <= abort_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign addr_done = addr_done_q;
    assign tx_done   = tx_done_q;
    assign abort     = abort_q;

endmodule

// File: tb/tb_slave_in_port.sv
// Directed bench for slave_in_port: single/burst writes and reads, address
// wrap, memory stall, abort, zero-length burst and reset mid-burst.
module tb_slave_in_port;

    localparam int AW = 12;
    localparam int WW = 8;
    localparam int BW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel, m_valid, addr_bus, burst_size_bus, w_data_bus, mem_ready;
    logic [2:0]    instruction;
    logic          s_ready, mem_we, mem_re, addr_done, tx_done, abort;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;

    int checks   = 0;
    int failures = 0;

    logic [AW+WW-1:0] wr_log[$];
    logic [AW-1:0]    rd_log[$];
    int               tx_cnt    = 0;
    int               abort_cnt = 0;

    always #5 clk = ~clk;

    slave_in_port #(.SLAVE_ADDR_SIZE(AW), .WORD_SIZE(WW), .BURST_SIZE(BW)) dut (
        .clk(clk), .rst(rst), .sel(sel), .instruction(instruction),
        .addr_bus(addr_bus), .burst_size_bus(burst_size_bus), .w_data_bus(w_data_bus),
        .m_valid(m_valid), .s_ready(s_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_ready(mem_ready),
        .addr_done(addr_done), .tx_done(tx_done), .abort(abort)
    );

    // Record memory handshakes and status pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we && mem_ready) wr_log.push_back({mem_addr, mem_wdata});
            if (mem_re && mem_ready) rd_log.push_back(mem_addr);
            if (tx_done) tx_cnt++;
            if (abort) abort_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one bit on the chosen bus (0 addr, 1 burst, 2 data) until accepted.
    task automatic send_bit(input int bus, input logic b);
        int guard;
        guard = 0;
        case (bus)
            0:       addr_bus = b;
            1:       burst_size_bus = b;
            default: w_data_bus = b;
        endcase
        m_valid = 1'b1;
        while (!s_ready && guard < 64) begin
            tick();
            guard++;
        end
        if (guard >= 64) check("s_ready_timeout", 32'd0, 32'd1);
        tick();
        m_valid = 1'b0;
    endtask

    task automatic send_field(input int bus, input logic [31:0] value, input int n);
        for (int i = 0; i < n; i++) send_bit(bus, value[i]);
    endtask

    task automatic start_op(input logic [2:0] op);
        sel         = 1'b1;
        instruction = op;
        tick();
        instruction = 3'd0;
    endtask

    task automatic wait_tx(input string tag);
        int start;
        int guard;
        start = tx_cnt;
        guard = 0;
        while (tx_cnt == start && guard < 200) begin
            tick();
            guard++;
        end
        check(tag, tx_cnt - start, 32'd1);
    endtask

    task automatic end_op();
        sel = 1'b0;
        tick();
        wr_log.delete();
        rd_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; instruction = 3'd0; m_valid = 1'b0;
        addr_bus = 1'b0; burst_size_bus = 1'b0; w_data_bus = 1'b0; mem_ready = 1'b0;

        // Reset values, and s_ready rising on the first edge after release.
        #12;
        check("rst_flags", {26'd0, s_ready, mem_we, mem_re, addr_done, tx_done, abort}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        tick();
        rst = 1'b0;
        check("s_ready_before_edge", s_ready, 32'd0);
        tick();
        check("s_ready_after_edge", s_ready, 32'd1);

        // Single write 0x3C to 0xA5C.
        mem_ready = 1'b1;
        start_op(3'd2);
        send_field(0, 32'hA5C, AW);
        check("t1_addr_done", addr_done, 32'd1);
        send_field(2, 32'h3C, WW);
        check("t1_we", mem_we, 32'd1);
        check("t1_addr", mem_addr, 32'hA5C);
        check("t1_wdata", mem_wdata, 32'h3C);
        tick();
        check("t1_we_drop", mem_we, 32'd0);
        check("t1_tx_done", tx_done, 32'd1);
        tick();
        check("t1_tx_done_pulse", tx_done, 32'd0);
        check("t1_wr_count", wr_log.size(), 32'd1);
        check("t1_wr0", wr_log[0], 32'hA5C3C);
        end_op();

        // Burst write of three words wrapping past the top address.
        start_op(3'd4);
        send_field(0, 32'hFFE, AW);
        send_field(1, 32'd3, BW);
        send_field(2, 32'h11, WW);
        send_field(2, 32'h22, WW);
        send_field(2, 32'h33, WW);
        wait_tx("t2_tx_done");
        check("t2_wr_count", wr_log.size(), 32'd3);
        check("t2_wr0", wr_log[0], 32'hFFE11);
        check("t2_wr1", wr_log[1], 32'hFFF22);
        check("t2_wr2", wr_log[2], 32'h00033);
        end_op();

        // Burst read of four words, back to back.
        start_op(3'd3);
        send_field(0, 32'h010, AW);
        send_field(1, 32'd4, BW);
        for (int i = 0; i < 4; i++) begin
            check("t3_re", mem_re, 32'd1);
            check("t3_addr", mem_addr, 32'h010 + i);
            tick();
        end
        check("t3_re_drop", mem_re, 32'd0);
        check("t3_tx_done", tx_done, 32'd1);
        check("t3_rd_count", rd_log.size(), 32'd4);
        tick();
        end_op();

        // Memory stall on the first of two burst-write words.
        mem_ready = 1'b0;
        start_op(3'd4);
        send_field(0, 32'h300, AW);
        send_field(1, 32'd2, BW);
        send_field(2, 32'hA1, WW);
        w_data_bus = 1'b1;
        m_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_we_sready", {30'd0, mem_we, s_ready}, 32'b10);
            tick();
        end
        m_valid   = 1'b0;
        check("t4_no_write_in_stall", wr_log.size(), 32'd0);
        mem_ready = 1'b1;
        send_field(2, 32'h5E, WW);
        wait_tx("t4_tx_done");
        check("t4_wr_count", wr_log.size(), 32'd2);
        check("t4_wr0", wr_log[0], 32'h300A1);
        check("t4_wr1", wr_log[1], 32'h3015E);
        end_op();

        // Abort after four data bits, then a clean single write.
        start_op(3'd2);
        send_field(0, 32'h0F0, AW);
        send_field(2, 32'h96, 4);
        sel = 1'b0;
        tick();
        check("t5_abort", abort, 32'd1);
        check("t5_no_we", mem_we, 32'd0);
        tick();
        check("t5_abort_pulse", abort, 32'd0);
        check("t5_idle_ready", s_ready, 32'd1);
        check("t5_abort_count", abort_cnt, 32'd1);
        check("t5_no_write", wr_log.size(), 32'd0);
        start_op(3'd2);
        send_field(0, 32'h123, AW);
        send_field(2, 32'hC3, WW);
        wait_tx("t5_tx_done");
        check("t5_wr_count", wr_log.size(), 32'd1);
        check("t5_wr0", wr_log[0], 32'h123C3);
        end_op();

        // Zero-length burst transfers exactly one word.
        start_op(3'd4);
        send_field(0, 32'h7F0, AW);
        send_field(1, 32'd0, BW);
        send_field(2, 32'h5A, WW);
        wait_tx("t6_tx_done");
        tick();
        tick();
        check("t6_we_idle", mem_we, 32'd0);
        check("t6_wr_count", wr_log.size(), 32'd1);
        check("t6_wr0", wr_log[0], 32'h7F05A);
        end_op();

        // Reset in the middle of a ten-word burst read.
        start_op(3'd3);
        send_field(0, 32'h040, AW);
        send_field(1, 32'd10, BW);
        tick();
        tick();
        tick();
        rst = 1'b1;
        sel = 1'b0;
        #1;
        check("t7_rst_flags", {26'd0, s_ready, mem_we, mem_re, addr_done, tx_done, abort}, 32'd0);
        check("t7_rst_addr", mem_addr, 32'd0);
        check("t7_rst_wdata", mem_wdata, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        check("t7_sready_low", s_ready, 32'd0);
        tick();
        check("t7_sready_high", s_ready, 32'd1);
        tick();
        tick();
        check("t7_no_req", {30'd0, mem_we, mem_re}, 32'd0);
        check("t7_rd_count", rd_log.size(), 32'd3);
        check("t7_rd2", rd_log[2], 32'h042);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
